demux_4out: RTL
===============

DEMUX_4OUT -- requirements
Module: demux_4out

Interface
REQ-001 Parameter: WIDTH, 32, data width of the input and of every output channel.
REQ-002 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-003 rstd  input  1  reset; asynchronous, active-low.
REQ-004 demux_s  input  2  destination select: 00 -> a, 01 -> b, 10 -> c, 11 -> d.
REQ-005 in_valid  input  1  input word present.
REQ-006 in_ready  output  1  block can accept the input word this cycle.
REQ-007 in_data  input  WIDTH  input word.
REQ-008 out_valid_a/b/c/d  output  1 each  channel slot holds a word.
REQ-009 out_ready_a/b/c/d  input  1 each  channel consumer accepts the word this cycle.
REQ-010 out_data_a/b/c/d  output  WIDTH each  channel slot contents.
REQ-011 pending  output  3  number of currently full channel slots, 0..4.
REQ-012 accept_cnt  output  16  count of accepted input words.

Function
REQ-013 Each channel SHALL own one registered slot (data + valid bit); out_data_x/out_valid_x SHALL be driven directly from that slot's registers.
REQ-014 Input transfer SHALL occur in a cycle only when in_valid=1 and in_ready=1.
REQ-015 in_ready SHALL be combinational: in_ready = !out_valid_s OR out_ready_s, where s is the channel chosen by demux_s in the same cycle; other channels SHALL NOT affect in_ready.
REQ-016 in_ready SHALL NOT depend on in_valid.
REQ-017 On a transfer, in_data SHALL be written into slot s at the clock edge; out_valid_s SHALL be 1 in the next cycle (latency 1 cycle). There SHALL be no combinational path from in_data to any out_data.
REQ-018 Output transfer on channel x SHALL occur when out_valid_x=1 and out_ready_x=1; at that edge out_valid_x SHALL clear, unless REQ-019 applies.
REQ-019 If the same edge has an output transfer on channel s and an input transfer into s, the slot SHALL take the new word and out_valid_s SHALL remain 1 (full throughput, one word per cycle per channel).
REQ-020 While out_valid_x=1 and out_ready_x=0, out_data_x SHALL hold stable.
REQ-021 While out_valid_x=0, out_data_x SHALL hold its last written value (0 after reset).
REQ-022 Drains on different channels and one fill SHALL be independent and may all occur in the same cycle.
REQ-023 Input words with demux_s pointing at a full, stalled slot SHALL stall (in_ready=0), never overwrite or drop.
REQ-024 pending SHALL equal the registered popcount of the four out_valid bits.
REQ-025 accept_cnt SHALL increment by 1 on each input transfer and wrap from 16'hFFFF to 16'h0000.
REQ-026 in_data and demux_s SHALL be ignored when in_valid=0; demux_s changing while in_valid=1 and in_ready=0 SHALL be permitted, and in_ready SHALL follow the new select.

Reset
REQ-027 While rstd=0, regardless of clk: all out_valid_x=0, all out_data_x=0, pending=0, accept_cnt=0.
REQ-028 in_ready SHALL be 0 while rstd=0.
REQ-029 Reset asserted mid-operation SHALL discard all held words without any output transfer; the first cycle after rstd rises SHALL behave as after power-up reset.

Verification
REQ-030 Reset, then in_valid=1, demux_s=10, in_data=32'h1234_5678, out_ready_c=0 for 3 cycles -> out_valid_c=1 from cycle+1, out_data_c=32'h1234_5678 stable, in_ready=0 from cycle+1, pending=1, accept_cnt=1.
REQ-031 Slot a full, out_ready_a=1, in_valid=1, demux_s=00, data 32'hA0, 32'hA1, 32'hA2 on consecutive cycles -> out_data_a shows A0, A1, A2 on consecutive cycles, out_valid_a continuously 1, accept_cnt=3.
REQ-032 Slot b full, out_ready_b=0, in_valid=1 with demux_s=01 -> in_ready=0; switch demux_s=11 -> in_ready=1 same cycle, word lands in d, slot b unchanged.
REQ-033 Fill all four slots with distinct words, all ready=0 -> pending=4; raise out_ready_a and out_ready_c in one cycle -> pending=2 next cycle, b/d data unchanged.
REQ-034 Drive 65536 transfers -> accept_cnt returns to 16'h0000; one more -> 16'h0001.
REQ-035 With 3 slots full, pull rstd low between clock edges -> all out_valid=0, pending=0, accept_cnt=0 immediately; after release, a new word to channel a appears 1 cycle after acceptance.

Source files
------------

// File: rtl/demux_4out_if.sv
// Handshake/bus bundle for the 4-way demultiplexer: one input port with a
// destination select, four independent registered output channels, plus
// occupancy and acceptance counters.
interface demux_4out_if #(
    parameter int WIDTH = 32
) ();
    logic [1:0]       demux_s;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    logic             out_valid_a;
    logic             out_valid_b;
    logic             out_valid_c;
    logic             out_valid_d;
    logic             out_ready_a;
    logic             out_ready_b;
    logic             out_ready_c;
    logic             out_ready_d;
    logic [WIDTH-1:0] out_data_a;
    logic [WIDTH-1:0] out_data_b;
    logic [WIDTH-1:0] out_data_c;
    logic [WIDTH-1:0] out_data_d;

    logic [2:0]       pending;
    logic [15:0]      accept_cnt;

    // Producer/consumer side (testbench or upstream + downstream logic)
    modport master (
        output demux_s, in_valid, in_data,
        output out_ready_a, out_ready_b, out_ready_c, out_ready_d,
        input  in_ready,
        input  out_valid_a, out_valid_b, out_valid_c, out_valid_d,
        input  out_data_a, out_data_b, out_data_c, out_data_d,
        input  pending, accept_cnt
    );

    // Demultiplexer side
    modport slave (
        input  demux_s, in_valid, in_data,
        input  out_ready_a, out_ready_b, out_ready_c, out_ready_d,
        output in_ready,
        output out_valid_a, out_valid_b, out_valid_c, out_valid_d,
        output out_data_a, out_data_b, out_data_c, out_data_d,
        output pending, accept_cnt
    );
endinterface

// File: rtl/demux_4out.sv
// 4-way demultiplexer with one registered slot per output channel.
// A word is routed to the slot picked by demux_s; each slot drains on its own
// valid/ready handshake. A slot that drains and refills on the same edge stays
// full, so every channel can sustain one word per cycle.
module demux_4out #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rstd,
    demux_4out_if.slave  bus
);

    logic [3:0]       r_valid;
    logic [WIDTH-1:0] r_data [4];
    logic [2:0]       r_pending;
    logic [15:0]      r_accept_cnt;

    logic [3:0]       w_out_ready;
    logic [3:0]       w_fill;
    logic [3:0]       w_valid_nxt;
    logic [2:0]       w_pop_nxt;
    logic             w_sel_free;
    logic             w_in_ready;
    logic             w_fire;

    assign w_out_ready = {bus.out_ready_d, bus.out_ready_c,
                          bus.out_ready_b, bus.out_ready_a};

    // Only the selected slot decides acceptance; reset forces not-ready
    always_comb begin
        w_sel_free = !r_valid[bus.demux_s] || w_out_ready[bus.demux_s];
        w_in_ready = rstd && w_sel_free;
        w_fire     = bus.in_valid && w_in_ready;
    end

    // Next slot occupancy: a fill wins over a same-edge drain
    always_comb begin
        w_fill      = '0;
        w_valid_nxt = '0;
        w_pop_nxt   = '0;
        for (int i = 0; i < 4; i++) begin
            w_fill[i]      = w_fire && (bus.demux_s == 2'(i));
            w_valid_nxt[i] = w_fill[i] || (r_valid[i] && !w_out_ready[i]);
            w_pop_nxt      = w_pop_nxt + 3'(w_valid_nxt[i]);
        end
    end

    // Slot registers, occupancy count and acceptance counter
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            r_valid      <= '0;
            r_pending    <= '0;
            r_accept_cnt <= '0;
            for (int i = 0; i < 4; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid   <= w_valid_nxt;
            r_pending <= w_pop_nxt;
            if (w_fire) begin
                r_data[bus.demux_s] <= bus.in_data;
                r_accept_cnt        <= r_accept_cnt + 16'd1;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid_a = r_valid[0];
    assign bus.out_valid_b = r_valid[1];
    assign bus.out_valid_c = r_valid[2];
    assign bus.out_valid_d = r_valid[3];
    assign bus.out_data_a  = r_data[0];
    assign bus.out_data_b  = r_data[1];
    assign bus.out_data_c  = r_data[2];
    assign bus.out_data_d  = r_data[3];
    assign bus.pending     = r_pending;
    assign bus.accept_cnt  = r_accept_cnt;

endmodule
